// File: rtl/memory_access_pkg.sv
// rtl/memory_access_pkg.sv - shared instruction codes, FSM states and op decode for the memory stage
package memory_access_pkg;

  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  typedef enum logic [1:0] {
    MEM_STATE_IDLE = 2'd0,
    MEM_STATE_XFER = 2'd1,
    MEM_STATE_DONE = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    MEM_OP_NONE  = 2'd0,
    MEM_OP_READ  = 2'd1,
    MEM_OP_WRITE = 2'd2
  } mem_op_e;

  // Which kind of data-memory access an instruction performs
  function automatic mem_op_e decode_op(input logic [3:0] icode);
    case (icode)
      ICODE_RMMOVQ, ICODE_PUSHQ, ICODE_CALL: decode_op = MEM_OP_WRITE;
      ICODE_MRMOVQ, ICODE_RET, ICODE_POPQ:   decode_op = MEM_OP_READ;
      default:                               decode_op = MEM_OP_NONE;
    endcase
  endfunction

  // Stack pops take their address from valA; everything else uses valE
  function automatic logic addr_from_vala(input logic [3:0] icode);
    addr_from_vala = (icode == ICODE_RET) || (icode == ICODE_POPQ);
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// rtl/dmem_byte_ram.sv - single-port byte-wide data memory, synchronous write, combinational read
module dmem_byte_ram #(
  parameter int MEM_BYTES = 1024,
  parameter int AW        = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  // Contents start at zero and are deliberately untouched by any reset
  logic [7:0] mem [MEM_BYTES] = '{default: 8'h00};

  // Byte write on the rising edge
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read is asynchronous so each transfer cycle sees its byte immediately
  always_comb begin
    rdata = mem[addr];
  end

endmodule

// File: rtl/memory_access.sv
// rtl/memory_access.sv - memory stage: one 8-byte LE read or write, serialised a byte per cycle
module memory_access
  import memory_access_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int AW        = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  output logic        busy,
  output logic        done,
  output logic [63:0] valM,
  output logic        mem_err
);

  localparam logic [63:0] LAST_OK_ADDR = 64'(MEM_BYTES) - 64'd8;

  mem_state_e    state;
  mem_op_e       op_q;
  logic [2:0]    k;
  logic [AW-1:0] base_idx;
  logic [63:0]   wdata_q;
  logic [55:0]   asm_q;

  mem_op_e       op_in;
  logic [63:0]   addr_in;
  logic          fault_in;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_rdata;

  // Decode the incoming request; the fault compare is full 64-bit so addr+7 wrap is caught too
  always_comb begin
    op_in    = decode_op(icode);
    addr_in  = addr_from_vala(icode) ? valA : valE;
    fault_in = (op_in != MEM_OP_NONE) && (addr_in > LAST_OK_ADDR);
  end

  // RAM port: byte k of the captured base; store data is pre-shifted so byte k sits at [7:0]
  always_comb begin
    ram_addr = base_idx + AW'(k);
    ram_we   = (state == MEM_STATE_XFER) && (op_q == MEM_OP_WRITE);
  end

  dmem_byte_ram #(
    .MEM_BYTES(MEM_BYTES),
    .AW       (AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(wdata_q[7:0]),
    .rdata(ram_rdata)
  );

  // Control FSM with capture registers and little-endian read assembly
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= MEM_STATE_IDLE;
      op_q     <= MEM_OP_NONE;
      k        <= 3'd0;
      base_idx <= '0;
      wdata_q  <= 64'd0;
      asm_q    <= 56'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      valM     <= 64'd0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        MEM_STATE_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (op_in == MEM_OP_NONE || fault_in) begin
              state   <= MEM_STATE_DONE;
              done    <= 1'b1;
              valM    <= 64'd0;
              mem_err <= fault_in;
            end else begin
              state    <= MEM_STATE_XFER;
              op_q     <= op_in;
              k        <= 3'd0;
              base_idx <= addr_in[AW-1:0];
              wdata_q  <= (icode == ICODE_CALL) ? valP : valA;
            end
          end
        end
        MEM_STATE_XFER: begin
          k       <= k + 3'd1;
          wdata_q <= {8'h00, wdata_q[63:8]};
          asm_q   <= {ram_rdata, asm_q[55:8]};
          if (k == 3'd7) begin
            state   <= MEM_STATE_DONE;
            done    <= 1'b1;
            mem_err <= 1'b0;
            valM    <= (op_q == MEM_OP_READ) ? {ram_rdata, asm_q} : 64'd0;
          end
        end
        MEM_STATE_DONE: begin
          state <= MEM_STATE_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          k     <= 3'd0;
        end
        default: begin
          state <= MEM_STATE_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// tb/tb_memory_access.sv - directed self-checking bench for memory_access
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  icode = 4'h0;
  logic [63:0] valE = 64'd0;
  logic [63:0] valA = 64'd0;
  logic [63:0] valP = 64'd0;
  logic        busy;
  logic        done;
  logic [63:0] valM;
  logic        mem_err;

  int checks = 0;
  int failures = 0;

  memory_access #(.MEM_BYTES(1024), .AW(10)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .icode  (icode),
    .valE   (valE),
    .valA   (valA),
    .valP   (valP),
    .busy   (busy),
    .done   (done),
    .valM   (valM),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // Issue one op, scramble inputs after accept, return done latency and results at done
  task automatic run_op(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                        input logic [63:0] p, output int lat, output logic [63:0] m,
                        output logic err, output logic busy_ok);
    @(negedge clk);
    icode = ic; valE = e; valA = a; valP = p; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; icode = 4'h6; valE = ~e; valA = ~a; valP = ~p;
    lat = 1;
    busy_ok = 1'b1;
    @(negedge clk);
    while (!done && lat < 30) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (busy !== 1'b1) busy_ok = 1'b0;
    m = valM;
    err = mem_err;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, mem_err} !== 3'b000 || valM !== 64'd0) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b err=%b valM=%h required 0 0 0 0", busy, done, mem_err, valM);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_rmmovq();
    int lat; logic [63:0] m; logic err, bok;
    run_op(4'h4, 64'h100, 64'h1122334455667788, 64'h0, lat, m, err, bok);
    checks++;
    if (lat !== 9 || err !== 1'b0 || m !== 64'd0 || bok !== 1'b1) begin
      failures++;
      $display("FAIL rmmovq: lat=%0d err=%b valM=%h busy_ok=%b required 9 0 0 1", lat, err, m, bok);
    end
  endtask

  task automatic test_mrmovq();
    int lat; logic [63:0] m; logic err, bok;
    run_op(4'h5, 64'h100, 64'h0, 64'h0, lat, m, err, bok);
    checks++;
    if (lat !== 9 || err !== 1'b0 || m !== 64'h1122334455667788 || bok !== 1'b1) begin
      failures++;
      $display("FAIL mrmovq: lat=%0d err=%b valM=%h busy_ok=%b required 9 0 1122334455667788 1", lat, err, m, bok);
    end
    @(negedge clk);
    checks++;
    if (valM !== 64'h1122334455667788 || done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL valm_hold: valM=%h done=%b busy=%b required 1122334455667788 0 0", valM, done, busy);
    end
  endtask

  task automatic test_stack();
    int lat; logic [63:0] m; logic err, bok;
    run_op(4'h8, 64'h3F8, 64'hDEAD_BEEF_0000_0000, 64'h42, lat, m, err, bok);
    checks++;
    if (lat !== 9 || err !== 1'b0 || m !== 64'd0) begin
      failures++;
      $display("FAIL call: lat=%0d err=%b valM=%h required 9 0 0", lat, err, m);
    end
    run_op(4'h9, 64'hFFFF_FFFF_FFFF_FFF0, 64'h3F8, 64'h0, lat, m, err, bok);
    checks++;
    if (lat !== 9 || err !== 1'b0 || m !== 64'h42) begin
      failures++;
      $display("FAIL ret: lat=%0d err=%b valM=%h required 9 0 42", lat, err, m);
    end
    run_op(4'hA, 64'h10, 64'h0102_0304_0506_0708, 64'h99, lat, m, err, bok);
    run_op(4'hB, 64'h3000, 64'h10, 64'h0, lat, m, err, bok);
    checks++;
    if (lat !== 9 || err !== 1'b0 || m !== 64'h0102_0304_0506_0708) begin
      failures++;
      $display("FAIL push_pop: lat=%0d err=%b valM=%h required 9 0 0102030405060708", lat, err, m);
    end
  endtask

  task automatic test_faults();
    int lat; logic [63:0] m; logic err, bok;
    run_op(4'h5, 64'd1017, 64'h0, 64'h0, lat, m, err, bok);
    checks++;
    if (lat !== 1 || err !== 1'b1 || m !== 64'd0 || bok !== 1'b1) begin
      failures++;
      $display("FAIL fault_edge: lat=%0d err=%b valM=%h busy_ok=%b required 1 1 0 1", lat, err, m, bok);
    end
    run_op(4'h5, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h0, lat, m, err, bok);
    checks++;
    if (lat !== 1 || err !== 1'b1 || m !== 64'd0) begin
      failures++;
      $display("FAIL fault_wrap: lat=%0d err=%b valM=%h required 1 1 0", lat, err, m);
    end
    run_op(4'h4, 64'h3FC, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, lat, m, err, bok);
    checks++;
    if (lat !== 1 || err !== 1'b1) begin
      failures++;
      $display("FAIL fault_write: lat=%0d err=%b required 1 1", lat, err);
    end
    run_op(4'h5, 64'd1016, 64'h0, 64'h0, lat, m, err, bok);
    checks++;
    if (lat !== 9 || err !== 1'b0 || m !== 64'h42) begin
      failures++;
      $display("FAIL last_word: lat=%0d err=%b valM=%h required 9 0 42", lat, err, m);
    end
  endtask

  task automatic test_nomem();
    int lat; logic [63:0] m; logic err, bok;
    run_op(4'h6, 64'h100, 64'h100, 64'h100, lat, m, err, bok);
    checks++;
    if (lat !== 1 || err !== 1'b0 || m !== 64'd0 || bok !== 1'b1) begin
      failures++;
      $display("FAIL opq: lat=%0d err=%b valM=%h busy_ok=%b required 1 0 0 1", lat, err, m, bok);
    end
    run_op(4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, lat, m, err, bok);
    checks++;
    if (lat !== 1 || err !== 1'b0 || m !== 64'd0) begin
      failures++;
      $display("FAIL halt: lat=%0d err=%b valM=%h required 1 0 0", lat, err, m);
    end
  endtask

  task automatic test_back_to_back();
    int lat1; int lat2; logic idle_ok;
    @(negedge clk);
    icode = 4'h4; valE = 64'h300; valA = 64'hCAFE; valP = 64'h0; start = 1'b1;
    @(posedge clk);
    lat1 = 1;
    @(negedge clk);
    while (!done && lat1 < 30) begin
      @(negedge clk);
      lat1++;
    end
    @(negedge clk);
    idle_ok = (busy === 1'b0) && (done === 1'b0);
    lat2 = 1;
    while (!done && lat2 < 30) begin
      @(negedge clk);
      lat2++;
    end
    start = 1'b0;
    checks++;
    if (lat1 !== 9 || lat2 !== 10 || idle_ok !== 1'b1) begin
      failures++;
      $display("FAIL back_to_back: lat1=%0d gap=%0d idle_ok=%b required 9 10 1", lat1, lat2, idle_ok);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    int lat; logic [63:0] m; logic err, bok;
    run_op(4'h4, 64'h200, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0, lat, m, err, bok);
    @(negedge clk);
    icode = 4'h4; valE = 64'h200; valA = 64'h1122334455667788; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort_state: busy=%b done=%b required 0 0", busy, done);
    end
    rst_n = 1'b1;
    run_op(4'h5, 64'h200, 64'h0, 64'h0, lat, m, err, bok);
    checks++;
    if (lat !== 9 || m !== 64'hAAAA_AAAA_5566_7788) begin
      failures++;
      $display("FAIL abort_ram: lat=%0d valM=%h required 9 aaaaaaaa55667788", lat, m);
    end
  endtask

  initial begin
    test_reset();
    test_rmmovq();
    test_mrmovq();
    test_stack();
    test_faults();
    test_nomem();
    test_back_to_back();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
